// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared encodings for the registered ALU control sequencer.
// Holds the ALU control words, R-type funct codes, aluop classes, the
// micro-op kind produced by the decoder and the sequencer FSM states.
package alu_ctrl_pkg;

   // ALU control words (3 significant bits, zero-extended to GOUT_W)
   localparam logic [2:0] GOUT_AND  = 3'b000;
   localparam logic [2:0] GOUT_OR   = 3'b001;
   localparam logic [2:0] GOUT_ADD  = 3'b010;
   localparam logic [2:0] GOUT_SLL1 = 3'b011;
   localparam logic [2:0] GOUT_SUB  = 3'b110;
   localparam logic [2:0] GOUT_SLT  = 3'b111;

   // R-type function codes
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_JMOR = 6'b100111;

   // aluop classes after priority decode of aluop[2:0]
   typedef enum logic [1:0] {
      CLS_ADD   = 2'd0,
      CLS_SUB   = 2'd1,
      CLS_RTYPE = 2'd2,
      CLS_ANDI  = 2'd3
   } alu_cls_e;

   // how many beats an accepted instruction expands into
   typedef enum logic [1:0] {
      KIND_SINGLE = 2'd0,
      KIND_JMOR   = 2'd1,
      KIND_SHIFT  = 2'd2
   } kind_e;

   // sequencer FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_JMOR2 = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

   // Priority decode of the aluop class: andi beats sub beats R-type beats add.
   function automatic alu_cls_e aluop_class(input logic [2:0] aluop);
      alu_cls_e cls;
      casez (aluop)
         3'b1??:  cls = CLS_ANDI;
         3'b??1:  cls = CLS_SUB;
         3'b?10:  cls = CLS_RTYPE;
         3'b000:  cls = CLS_ADD;
         default: cls = CLS_ADD;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: instruction-in / micro-op-out handshake bundle of the
// ALU control sequencer. The slave modport is the sequencer side, the
// master modport is the control unit / datapath side that drives it.
interface alu_ctrl_seq_if #(
   parameter int ALUOP_W = 3,
   parameter int GOUT_W  = 3,
   parameter int SHAMT_W = 5
);
   // instruction side
   logic               in_valid;
   logic               in_ready;
   logic [ALUOP_W-1:0] aluop;
   logic [5:0]         funct;
   logic [SHAMT_W-1:0] shamt;
   // micro-op side
   logic               out_valid;
   logic               out_ready;
   logic [GOUT_W-1:0]  gout;
   logic               jmorsig;
   logic               out_last;
   // status
   logic               busy;
   logic               illegal;

   modport slave (
      input  in_valid, aluop, funct, shamt, out_ready,
      output in_ready, out_valid, gout, jmorsig, out_last, busy, illegal
   );

   modport master (
      output in_valid, aluop, funct, shamt, out_ready,
      input  in_ready, out_valid, gout, jmorsig, out_last, busy, illegal
   );
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational aluop/funct/shamt decode into the first
// ALU control word, the beat kind and the illegal-funct flag.
// Optional feature macro: ALU_CTRL_ILLEGAL_EN (flags unknown R-type funct).
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 3,
   parameter int SHAMT_W = 5
) (
   input  logic [ALUOP_W-1:0] aluop_i,
   input  logic [5:0]         funct_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic [2:0]         gout_o,
   output kind_e              kind_o,
   output logic               illegal_o
);

   localparam logic [SHAMT_W-1:0] SHAMT_ONE = SHAMT_W'(1);

   // Decode the instruction class, then the R-type funct table.
   always_comb begin
      gout_o    = GOUT_ADD;
      kind_o    = KIND_SINGLE;
      illegal_o = 1'b0;
      case (aluop_class(aluop_i[2:0]))
         CLS_ANDI: gout_o = GOUT_AND;
         CLS_SUB:  gout_o = GOUT_SUB;
         CLS_ADD:  gout_o = GOUT_ADD;
         CLS_RTYPE: begin
            case (funct_i)
               FN_ADD: gout_o = GOUT_ADD;
               FN_SUB: gout_o = GOUT_SUB;
               FN_AND: gout_o = GOUT_AND;
               FN_OR:  gout_o = GOUT_OR;
               FN_SLT: gout_o = GOUT_SLT;
               FN_SLL: begin
                  // shamt 0/1 collapses to one sll1 beat
                  gout_o = GOUT_SLL1;
                  if (shamt_i > SHAMT_ONE) begin
                     kind_o = KIND_SHIFT;
                  end else begin
                     kind_o = KIND_SINGLE;
                  end
               end
               FN_JMOR: begin
                  gout_o = GOUT_OR;
                  kind_o = KIND_JMOR;
               end
               default: begin
                  gout_o = GOUT_ADD;
`ifdef ALU_CTRL_ILLEGAL_EN
                  illegal_o = 1'b1;
`else
                  illegal_o = 1'b0;
`endif
               end
            endcase
         end
         default: gout_o = GOUT_ADD;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control sequencer. Accepts one instruction
// at a time, expands jmor into two beats and sll into shamt sll1 beats, and
// presents each micro-op through a valid/ready output register.
// Optional feature macro: ALU_CTRL_ILLEGAL_EN (see alu_ctrl_decode).
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 3,
   parameter int GOUT_W  = 3,
   parameter int SHAMT_W = 5
) (
   input  logic          clk,
   input  logic          reset,
   alu_ctrl_seq_if.slave bus
);

   localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

   state_e              state_q,     state_d;
   logic [SHAMT_W-1:0]  cnt_q,       cnt_d;
   logic                out_valid_q, out_valid_d;
   logic [GOUT_W-1:0]   gout_q,      gout_d;
   logic                jmorsig_q,   jmorsig_d;
   logic                out_last_q,  out_last_d;
   logic                illegal_q,   illegal_d;
   logic                busy_q,      busy_d;

   logic [2:0]          dec_gout_s;
   kind_e               dec_kind_s;
   logic                dec_illegal_s;
   logic                adv_s;
   logic                in_ready_s;
   logic                accept_s;

   alu_ctrl_decode #(
      .ALUOP_W (ALUOP_W),
      .SHAMT_W (SHAMT_W)
   ) u_decode (
      .aluop_i   (bus.aluop),
      .funct_i   (bus.funct),
      .shamt_i   (bus.shamt),
      .gout_o    (dec_gout_s),
      .kind_o    (dec_kind_s),
      .illegal_o (dec_illegal_s)
   );

   // The output register may load whenever it is empty or being drained.
   assign adv_s      = bus.out_ready | ~out_valid_q;
   assign in_ready_s = (state_q == ST_IDLE) & adv_s;
   assign accept_s   = bus.in_valid & in_ready_s;

   // Next-state, counter and next micro-op for the output register.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      gout_d      = gout_q;
      jmorsig_d   = jmorsig_q;
      out_last_d  = out_last_q;
      illegal_d   = illegal_q;
      if (adv_s) begin
         out_valid_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  out_valid_d = 1'b1;
                  gout_d      = GOUT_W'(dec_gout_s);
                  jmorsig_d   = 1'b0;
                  illegal_d   = dec_illegal_s;
                  case (dec_kind_s)
                     KIND_JMOR: begin
                        out_last_d = 1'b0;
                        state_d    = ST_JMOR2;
                     end
                     KIND_SHIFT: begin
                        out_last_d = 1'b0;
                        cnt_d      = bus.shamt - CNT_ONE;
                        state_d    = ST_SHIFT;
                     end
                     default: begin
                        out_last_d = 1'b1;
                        state_d    = ST_IDLE;
                     end
                  endcase
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_JMOR2: begin
               out_valid_d = 1'b1;
               gout_d      = GOUT_W'(GOUT_ADD);
               jmorsig_d   = 1'b1;
               out_last_d  = 1'b1;
               illegal_d   = 1'b0;
               state_d     = ST_IDLE;
            end
            ST_SHIFT: begin
               // counter reaches zero on the final beat, so it never wraps
               out_valid_d = 1'b1;
               gout_d      = GOUT_W'(GOUT_SLL1);
               jmorsig_d   = 1'b0;
               illegal_d   = 1'b0;
               cnt_d       = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  out_last_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  out_last_d = 1'b0;
                  state_d    = ST_SHIFT;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
      busy_d = (state_d != ST_IDLE) | out_valid_d;
   end

   // State, counter and output register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         gout_q      <= '0;
         jmorsig_q   <= 1'b0;
         out_last_q  <= 1'b0;
         illegal_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         gout_q      <= gout_d;
         jmorsig_q   <= jmorsig_d;
         out_last_q  <= out_last_d;
         illegal_q   <= illegal_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_q;
   assign bus.gout      = gout_q;
   assign bus.jmorsig   = jmorsig_q;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = busy_q;
   assign bus.illegal   = illegal_q;

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Parametrised, registered successor to the combinational ALU control decoder.
- Decodes aluop/funct into ALU control words (gout) and issues them through a valid/ready output register.
- Compound instructions are sequenced as multi-beat micro-op streams:
  - jmor: two beats.
  - iterative sll: shamt beats.
- Sits between the main control unit and the ALU/datapath sequencer.

Parameters:
- ALUOP_W, 3, aluop width; bits above [2] are ignored by decode.
- GOUT_W, 3, ALU control width (min 3); upper bits zero-filled.
- SHAMT_W, 5, shift-amount width; max iterative shift 2^SHAMT_W-1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  block accepts instruction this cycle.
- aluop  input  ALUOP_W  ALU op class from main control.
- funct  input  6  R-type function code.
- shamt  input  SHAMT_W  shift amount for sll.
- out_valid  output  1  micro-op in output register valid.
- out_ready  input  1  consumer takes micro-op.
- gout  output  GOUT_W  ALU control word.
- jmorsig  output  1  jmor jump-select, valid with out_valid.
- out_last  output  1  final micro-op of the instruction.
- busy  output  1  FSM not in IDLE or output register occupied.
- illegal  output  1  undecodable funct (see Optional Feature).

Behaviour:
- Reset: state IDLE; out_valid=0, gout=0, jmorsig=0, out_last=0, illegal=0, shift counter=0. Reset mid-sequence aborts it; no further beats are issued.
- gout encodings: and=000, or=001, add=010, sll1=011, sub=110, slt=111.
- aluop decode, priority top-down on aluop[2:0]:
  - 1xx -> and (andi).
  - xx1 -> sub.
  - x10 -> R-type.
  - 000 -> add.
- R-type funct decode:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - 000000 sll.
  - 100111 jmor.
  - Any other value -> add.
- Handshake:
  - Output register advances when out_ready=1 or out_valid=0.
  - in_ready = (state==IDLE) && (out_valid==0 || out_ready).
  - Accept = in_valid && in_ready.
  - Latency: accept at edge N gives out_valid=1 with the first micro-op after edge N.
  - Output fields hold stable while out_valid=1 and out_ready=0.
- FSM states and transitions:
  - IDLE: on accept, load first beat.
    - Single-beat ops: out_last=1, remain IDLE.
    - jmor: beat1 = or, jmorsig=0, out_last=0 -> JMOR2.
    - sll with shamt>1: beat1 = sll1, counter=shamt-1 -> SHIFT.
    - sll with shamt 0 or 1: single beat sll1, out_last=1. shamt=0 still emits one beat; the datapath ignores it.
  - JMOR2: when beat1 drains, load add with jmorsig=1, out_last=1 -> IDLE.
  - SHIFT: each drain loads another sll1 and decrements the counter. The beat loaded when counter==1 carries out_last=1 -> IDLE.
  - A shamt of all ones yields exactly 2^SHAMT_W-1 beats; the counter never wraps.
- Simultaneous events: the last-beat drain and a new accept in the same cycle are permitted in IDLE, giving back-to-back instructions with no bubble. in_ready stays 0 throughout JMOR2/SHIFT.
- jmorsig=0 on every beat except jmor beat 2.

Optional Feature:
- Macro ALU_CTRL_ILLEGAL_EN.
- Defined: an R-type funct outside the table sets illegal=1 on its single add beat (out_last=1). illegal clears on the next loaded beat.
- Undefined: illegal is tied 0; unknown funct silently decodes to add.

Decomposition:
- Package alu_ctrl_pkg holds:
  - gout localparams (GOUT_AND..GOUT_SLT).
  - funct codes (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_JMOR).
  - aluop class codes.
  - FSM state encoding (IDLE, JMOR2, SHIFT).
- Sub-module alu_ctrl_decode: combinational aluop/funct/shamt -> {first gout, kind (single/jmor/shift), illegal}. Instantiated once; the top holds the FSM, counter and output register.

Test Plan:
- reset=1 for 2 cycles, then aluop=010 funct=100010 in_valid=1, out_ready=1 -> next cycle gout=110, out_last=1, jmorsig=0; in_ready=1 throughout.
- aluop=010 funct=100111 out_ready=1 -> beat1 gout=001 jmorsig=0 out_last=0; beat2 gout=010 jmorsig=1 out_last=1; in_ready=0 during beat1.
- aluop=010 funct=000000 shamt=3 with out_ready toggling 1,0,1,1 -> exactly 3 sll1 beats, held stable while stalled, out_last only on beat 3.
- Back-to-back: aluop=000 then aluop=100 with out_ready=1 -> gout 010 then 000 on consecutive cycles, no bubble.
- Reset asserted mid-SHIFT (shamt=31, after 4 beats) -> next cycle out_valid=0, busy=0; next accepted op issues normally.
- With ALU_CTRL_ILLEGAL_EN: aluop=010 funct=111111 -> gout=010, illegal=1, out_last=1. Without the macro -> illegal=0.
